// File: rtl/adat_frame_reader_if.sv
// adat_frame_reader_if
// Sample output bus of the ADAT frame reader.
//   sample_data_o     24-bit sample, MSB = first bit of the slot
//   sample_channel_o  channel 0..7 of sample_data_o
//   sample_valid_o    sample available (held until accepted)
//   sample_ready_i    consumer accepts the sample
//   frame_done_o      one-cycle pulse after channel 7 is accepted
//   overrun_o         one-cycle pulse when a frame is dropped
// master: the reader; slave: the sample consumer.
interface adat_frame_reader_if;
    logic [23:0] sample_data_o;
    logic [2:0]  sample_channel_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        frame_done_o;
    logic        overrun_o;

    modport master (
        output sample_data_o,
        output sample_channel_o,
        output sample_valid_o,
        input  sample_ready_i,
        output frame_done_o,
        output overrun_o
    );

    modport slave (
        input  sample_data_o,
        input  sample_channel_o,
        input  sample_valid_o,
        output sample_ready_i,
        input  frame_done_o,
        input  overrun_o
    );
endinterface

// File: rtl/adat_frame_reader.sv
// adat_frame_reader
// Reads the newest complete ADAT frame out of a single-bit-wide channel
// buffer and presents its eight 24-bit samples one at a time on a
// valid/ready bus. A frame starts when the decoder reports a new frame
// index while locked; one extra request is queued while busy, further
// requests are dropped and flagged as overruns.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   has_sync_i              decoder lock
//   last_good_frame_idx_i   index of newest complete frame
//   ram_read_addr_o         buffer read address {frame, channel, bit}
//   ram_read_data_i         buffer read data, one cycle after the address
//   smp                     sample output bus (adat_frame_reader_if.master)
//   overrun_count_o         saturating overrun counter (only with
//                           ADAT_READER_OVERRUN_CNT_EN defined)
//
// Optional feature macro: ADAT_READER_OVERRUN_CNT_EN
module adat_frame_reader #(
    parameter int  CIRC_BUF_BITS = 3,
    localparam int AW            = CIRC_BUF_BITS + 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     has_sync_i,
    input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
    output logic [AW-1:0]            ram_read_addr_o,
    input  logic                     ram_read_data_i,
    adat_frame_reader_if.master      smp
`ifdef ADAT_READER_OVERRUN_CNT_EN
    ,
    output logic [7:0]               overrun_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t                   state_r;
    logic [CIRC_BUF_BITS-1:0] prev_idx_r;
    logic [CIRC_BUF_BITS-1:0] frame_r;
    logic                     pending_r;
    logic [2:0]               channel_r;
    logic [4:0]               bit_cnt_r;
    logic [23:0]              shift_r;
    logic [AW-1:0]            addr_r;
    logic                     valid_r;
    logic                     frame_done_r;
    logic                     overrun_r;

    logic event_w;
    logic busy_event_w;
    logic overrun_event_w;
    logic handshake_w;

    assign event_w         = has_sync_i && (last_good_frame_idx_i != prev_idx_r);
    // The channel-7 handshake cycle is still PRESENT, so a coinciding
    // event is treated as arriving while busy.
    assign busy_event_w    = event_w && (state_r != IDLE);
    assign overrun_event_w = busy_event_w && pending_r;
    assign handshake_w     = (state_r == PRESENT) && valid_r && smp.sample_ready_i;

    assign ram_read_addr_o      = addr_r;
    assign smp.sample_data_o    = shift_r;
    assign smp.sample_channel_o = channel_r;
    assign smp.sample_valid_o   = valid_r;
    assign smp.frame_done_o     = frame_done_r;
    assign smp.overrun_o        = overrun_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            prev_idx_r   <= '0;
            frame_r      <= '0;
            pending_r    <= 1'b0;
            channel_r    <= 3'd0;
            bit_cnt_r    <= 5'd0;
            shift_r      <= 24'd0;
            addr_r       <= '0;
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            prev_idx_r   <= last_good_frame_idx_i;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;

            if (!has_sync_i) begin
                state_r   <= IDLE;
                valid_r   <= 1'b0;
                pending_r <= 1'b0;
            end else begin
                if (busy_event_w) begin
                    if (pending_r) overrun_r <= 1'b1;
                    else           pending_r <= 1'b1;
                end

                case (state_r)
                    IDLE: begin
                        if (event_w || pending_r) begin
                            frame_r   <= last_good_frame_idx_i;
                            pending_r <= 1'b0;
                            channel_r <= 3'd0;
                            bit_cnt_r <= 5'd0;
                            addr_r    <= {last_good_frame_idx_i, 3'd0, 5'd0};
                            state_r   <= FETCH;
                        end
                    end

                    // bit_cnt_r = n: address for bit n is on the bus,
                    // data for bit n-1 is on ram_read_data_i.
                    FETCH: begin
                        if (bit_cnt_r != 5'd0)
                            shift_r <= {shift_r[22:0], ram_read_data_i};
                        if (bit_cnt_r < 5'd23)
                            addr_r <= {frame_r, channel_r, bit_cnt_r + 5'd1};
                        if (bit_cnt_r == 5'd24) begin
                            state_r <= PRESENT;
                            valid_r <= 1'b1;
                        end
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end

                    PRESENT: begin
                        if (handshake_w) begin
                            valid_r <= 1'b0;
                            if (channel_r == 3'd7) begin
                                state_r      <= IDLE;
                                frame_done_r <= 1'b1;
                            end else begin
                                channel_r <= channel_r + 3'd1;
                                bit_cnt_r <= 5'd0;
                                addr_r    <= {frame_r, channel_r + 3'd1, 5'd0};
                                state_r   <= FETCH;
                            end
                        end
                    end

                    default: begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ADAT_READER_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_r;

    assign overrun_count_o = overrun_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            overrun_cnt_r <= 8'd0;
        else if (has_sync_i && overrun_event_w && (overrun_cnt_r != 8'd255))
            overrun_cnt_r <= overrun_cnt_r + 8'd1;
    end
`endif

endmodule

// File: tb/tb_adat_frame_reader.sv
module tb_adat_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        has_sync;
    logic [2:0]  idx;
    logic [10:0] addr;
    logic        ram_q;
    logic        mem [0:2047];
`ifdef ADAT_READER_OVERRUN_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    adat_frame_reader_if smp_if ();

    adat_frame_reader #(.CIRC_BUF_BITS(3)) dut (
`ifdef ADAT_READER_OVERRUN_CNT_EN
        .overrun_count_o       (ovr_cnt),
`endif
        .clk_i                 (clk),
        .reset_i               (rst),
        .has_sync_i            (has_sync),
        .last_good_frame_idx_i (idx),
        .ram_read_addr_o       (addr),
        .ram_read_data_i       (ram_q),
        .smp                   (smp_if)
    );

    always #5 clk = ~clk;

    // Channel buffer: registered single-bit read.
    always @(posedge clk) ram_q <= mem[addr];

    function automatic logic [23:0] pat(input int f, input int c);
        logic [7:0] fb;
        logic [7:0] cb;
        fb = f[7:0];
        cb = c[7:0];
        if (f == 3 && c == 0) return 24'hA5C3F0;
        return {fb, cb, 8'h96} ^ 24'h5A0F3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!smp_if.sample_valid_o && n < 100);
    endtask

    initial begin
        int n;
        int cnt_v;
        int cnt_fd;
        int cnt_ov;
        logic [23:0] v;

        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++) begin
                v = pat(f, c);
                for (int b = 0; b < 32; b++)
                    mem[f * 256 + c * 32 + b] = (b < 24) ? v[23 - b] : 1'b1;
            end

        // Reset
        rst = 1'b1; has_sync = 1'b0; idx = 3'd0; smp_if.sample_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_valid",  32'(smp_if.sample_valid_o), 32'd0);
        chk("rst_data",   32'(smp_if.sample_data_o), 32'd0);
        chk("rst_chan",   32'(smp_if.sample_channel_o), 32'd0);
        chk("rst_fdone",  32'(smp_if.frame_done_o), 32'd0);
        chk("rst_ovr",    32'(smp_if.overrun_o), 32'd0);
        chk("rst_addr",   32'(addr), 32'd0);

        // Full frame 3, ready high
        rst = 1'b0; idx = 3'd2; smp_if.sample_ready_i = 1'b1;
        tick();
        has_sync = 1'b1;
        tick();
        tick();
        chk("no_event_valid", 32'(smp_if.sample_valid_o), 32'd0);
        idx = 3'd3;
        for (int c = 0; c < 8; c++) begin
            wait_valid(n);
            chk($sformatf("A_lat_ch%0d", c), 32'(n), 32'd26);
            chk($sformatf("A_data_ch%0d", c), 32'(smp_if.sample_data_o), 32'(pat(3, c)));
            chk($sformatf("A_chan_ch%0d", c), 32'(smp_if.sample_channel_o), 32'(c));
        end
        tick();
        chk("A_fdone", 32'(smp_if.frame_done_o), 32'd1);
        chk("A_valid_after", 32'(smp_if.sample_valid_o), 32'd0);
        tick();
        chk("A_fdone_pulse", 32'(smp_if.frame_done_o), 32'd0);

        // Frame 4 with ready held low on channel 4
        idx = 3'd4;
        for (int c = 0; c < 4; c++) begin
            wait_valid(n);
            chk($sformatf("B_data_ch%0d", c), 32'(smp_if.sample_data_o), 32'(pat(4, c)));
        end
        tick();
        smp_if.sample_ready_i = 1'b0;
        wait_valid(n);
        chk("B_lat_ch4", 32'(n), 32'd25);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("B_hold_valid%0d", k), 32'(smp_if.sample_valid_o), 32'd1);
            chk($sformatf("B_hold_data%0d", k), 32'(smp_if.sample_data_o), 32'(pat(4, 4)));
            chk($sformatf("B_hold_chan%0d", k), 32'(smp_if.sample_channel_o), 32'd4);
            chk($sformatf("B_hold_addr%0d", k), 32'(addr), 32'({3'd4, 3'd4, 5'd23}));
            tick();
        end
        smp_if.sample_ready_i = 1'b1;
        for (int c = 5; c < 8; c++) begin
            wait_valid(n);
            chk($sformatf("B_lat_ch%0d", c), 32'(n), 32'd26);
            chk($sformatf("B_data_ch%0d", c), 32'(smp_if.sample_data_o), 32'(pat(4, c)));
        end
        tick();
        chk("B_fdone", 32'(smp_if.frame_done_o), 32'd1);

        // Two index changes while busy: pending then overrun
        tick();
        idx = 3'd5;
        repeat (5) tick();
        idx = 3'd6;
        tick();
        chk("C_no_ovr_first", 32'(smp_if.overrun_o), 32'd0);
        repeat (3) tick();
        idx = 3'd7;
        tick();
        chk("C_ovr_pulse", 32'(smp_if.overrun_o), 32'd1);
        tick();
        chk("C_ovr_clear", 32'(smp_if.overrun_o), 32'd0);
`ifdef ADAT_READER_OVERRUN_CNT_EN
        chk("C_ovr_count", 32'(ovr_cnt), 32'd1);
`endif
        for (int c = 0; c < 8; c++) begin
            wait_valid(n);
            chk($sformatf("C_data_ch%0d", c), 32'(smp_if.sample_data_o), 32'(pat(5, c)));
            chk($sformatf("C_chan_ch%0d", c), 32'(smp_if.sample_channel_o), 32'(c));
        end
        tick();
        chk("C_fdone", 32'(smp_if.frame_done_o), 32'd1);
        wait_valid(n);
        chk("C_pend_lat", 32'(n), 32'd26);
        chk("C_pend_data", 32'(smp_if.sample_data_o), 32'(pat(7, 0)));
        chk("C_pend_chan", 32'(smp_if.sample_channel_o), 32'd0);

        // Sync loss during channel 2 fetch
        wait_valid(n);
        chk("D_lat_ch1", 32'(n), 32'd26);
        chk("D_data_ch1", 32'(smp_if.sample_data_o), 32'(pat(7, 1)));
        repeat (5) tick();
        has_sync = 1'b0;
        tick();
        chk("D_valid_drop", 32'(smp_if.sample_valid_o), 32'd0);
        cnt_v = 0; cnt_fd = 0;
        repeat (40) begin
            tick();
            if (smp_if.sample_valid_o) cnt_v++;
            if (smp_if.frame_done_o) cnt_fd++;
        end
        chk("D_nosync_valid", 32'(cnt_v), 32'd0);
        chk("D_nosync_fdone", 32'(cnt_fd), 32'd0);
        has_sync = 1'b1;
        cnt_v = 0;
        repeat (30) begin
            tick();
            if (smp_if.sample_valid_o) cnt_v++;
        end
        chk("D_resync_noidx", 32'(cnt_v), 32'd0);
        idx = 3'd1;
        wait_valid(n);
        chk("D_restart_lat", 32'(n), 32'd26);
        chk("D_restart_chan", 32'(smp_if.sample_channel_o), 32'd0);
        chk("D_restart_data", 32'(smp_if.sample_data_o), 32'(pat(1, 0)));

        // Reset while presenting
        smp_if.sample_ready_i = 1'b0;
        rst = 1'b1; idx = 3'd0;
        tick();
        chk("E_valid", 32'(smp_if.sample_valid_o), 32'd0);
        chk("E_data",  32'(smp_if.sample_data_o), 32'd0);
        chk("E_chan",  32'(smp_if.sample_channel_o), 32'd0);
        chk("E_addr",  32'(addr), 32'd0);
        chk("E_fdone", 32'(smp_if.frame_done_o), 32'd0);
        chk("E_ovr",   32'(smp_if.overrun_o), 32'd0);
`ifdef ADAT_READER_OVERRUN_CNT_EN
        chk("E_ovr_count", 32'(ovr_cnt), 32'd0);
`endif
        rst = 1'b0;
        cnt_v = 0; cnt_fd = 0; cnt_ov = 0;
        repeat (30) begin
            tick();
            if (smp_if.sample_valid_o) cnt_v++;
            if (smp_if.frame_done_o) cnt_fd++;
            if (smp_if.overrun_o) cnt_ov++;
        end
        chk("E_post_valid", 32'(cnt_v), 32'd0);
        chk("E_post_fdone", 32'(cnt_fd), 32'd0);
        chk("E_post_ovr",   32'(cnt_ov), 32'd0);

`ifdef ADAT_READER_OVERRUN_CNT_EN
        // Many forced overruns saturate the counter
        smp_if.sample_ready_i = 1'b1;
        repeat (400) begin
            idx = idx ^ 3'd1;
            tick();
        end
        chk("F_ovr_sat", 32'(ovr_cnt), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
